// File: rtl/tx_samples_serializer_if.sv
// Frame handoff bus between the sample producer and the TX serializer.
// The producer drives a full frame plus valid; the serializer returns ready.
interface tx_samples_serializer_if #(
  parameter int NUM_LANES = 20,
  parameter int DATA_W    = 16
);
  logic [NUM_LANES*DATA_W-1:0] idata_lanes;
  logic                        ivalid;
  logic                        oready;

  modport master (
    output idata_lanes,
    output ivalid,
    input  oready
  );

  modport slave (
    input  idata_lanes,
    input  ivalid,
    output oready
  );
endinterface

// File: rtl/tx_samples_serializer.sv
// Re-interleaves a parallel frame of lane samples into one serial stream.
// Shadow + active frame buffers let the next frame arrive during emission.
module tx_samples_serializer #(
  parameter int NUM_LANES = 20,
  parameter int DATA_W    = 16
) (
  input  logic                     ctx_clk,
  input  logic                     rtx_rst,
  input  logic                     etx_en,
  input  logic                     inew_sample_trig,
  tx_samples_serializer_if.slave   frame_if,
  output logic signed [DATA_W-1:0] odata,
  output logic                     odata_valid,
  output logic [4:0]               olane_idx,
  output logic                     ounderrun
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  typedef logic [NUM_LANES-1:0][DATA_W-1:0] frame_t;

  state_t     r_state;
  frame_t     r_shadow;
  frame_t     r_active;
  logic       r_shadow_full;
  logic [4:0] r_lane;

  logic w_trig;
  logic w_accept;
  logic w_emit;
  logic w_last;
  logic w_xfer;
  logic w_underrun;

  assign w_trig     = inew_sample_trig && etx_en;
  assign w_accept   = frame_if.ivalid && !r_shadow_full;
  assign w_emit     = w_trig && (r_state == STREAM);
  assign w_last     = w_emit && (r_lane == 5'(NUM_LANES - 1));
  assign w_underrun = w_trig && (r_state == IDLE);
  // Refill on the final lane's emit so the next trig hits lane 0 with no gap.
  assign w_xfer     = r_shadow_full && ((r_state == IDLE) || w_last);

  assign frame_if.oready = !r_shadow_full;

  always_ff @(posedge ctx_clk or negedge rtx_rst) begin
    if (!rtx_rst) begin
      r_state       <= IDLE;
      r_shadow      <= '0;
      r_active      <= '0;
      r_shadow_full <= 1'b0;
      r_lane        <= '0;
      odata         <= '0;
      odata_valid   <= 1'b0;
      olane_idx     <= '0;
      ounderrun     <= 1'b0;
    end else begin
      odata_valid <= 1'b0;
      ounderrun   <= w_underrun;

      if (w_accept) begin
        r_shadow      <= frame_if.idata_lanes;
        r_shadow_full <= 1'b1;
      end

      if (w_emit) begin
        odata       <= r_active[r_lane];
        olane_idx   <= r_lane;
        odata_valid <= 1'b1;
        if (w_last) begin
          r_lane  <= '0;
          r_state <= IDLE;
        end else begin
          r_lane <= r_lane + 5'd1;
        end
      end

      // Transfer wins over the wrap-to-IDLE above when both fire.
      if (w_xfer) begin
        r_active      <= r_shadow;
        r_shadow_full <= 1'b0;
        r_lane        <= '0;
        r_state       <= STREAM;
      end
    end
  end

endmodule

// File: tb/tb_tx_samples_serializer.sv
// Directed bench for tx_samples_serializer.
// Trig vectors come from a table; loads and reset are hand sequenced.
module tb_tx_samples_serializer;

  localparam int NL = 20;
  localparam int DW = 16;

  typedef struct {
    logic en;
    logic exp_v;
    logic exp_ur;
    int   exp_lane;
    int   exp_data;
  } vec_t;

  logic                 ctx_clk = 1'b0;
  logic                 rtx_rst = 1'b0;
  logic                 etx_en = 1'b0;
  logic                 inew_sample_trig = 1'b0;
  logic signed [DW-1:0] odata;
  logic                 odata_valid;
  logic [4:0]           olane_idx;
  logic                 ounderrun;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  tx_samples_serializer_if #(.NUM_LANES(NL), .DATA_W(DW)) fif ();

  tx_samples_serializer #(
    .NUM_LANES(NL),
    .DATA_W   (DW)
  ) dut (
    .ctx_clk         (ctx_clk),
    .rtx_rst         (rtx_rst),
    .etx_en          (etx_en),
    .inew_sample_trig(inew_sample_trig),
    .frame_if        (fif.slave),
    .odata           (odata),
    .odata_valid     (odata_valid),
    .olane_idx       (olane_idx),
    .ounderrun       (ounderrun)
  );

  always #5 ctx_clk = ~ctx_clk;

  task automatic tick();
    @(posedge ctx_clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(logic en, logic v, logic ur, int lane, int data);
    vec_t r;
    r.en       = en;
    r.exp_v    = v;
    r.exp_ur   = ur;
    r.exp_lane = lane;
    r.exp_data = data;
    vecs.push_back(r);
  endtask

  function automatic logic [NL*DW-1:0] mk_frame(int base);
    logic [NL*DW-1:0] f;
    for (int i = 0; i < NL; i++) f[i*DW +: DW] = 16'(base + i);
    return f;
  endfunction

  task automatic load_frame(logic [NL*DW-1:0] f);
    int n;
    n = 0;
    while (!fif.oready && n < 100) begin
      tick();
      n++;
    end
    if (!fif.oready) chk("oready_timeout", 0, 1);
    fif.idata_lanes = f;
    fif.ivalid      = 1'b1;
    tick();
    fif.ivalid = 1'b0;
  endtask

  task automatic run_vecs(int n, string tag);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v = vecs.pop_front();
      etx_en           = v.en;
      inew_sample_trig = 1'b1;
      tick();
      inew_sample_trig = 1'b0;
      chk($sformatf("%s[%0d].valid", tag, k), int'(odata_valid), int'(v.exp_v));
      chk($sformatf("%s[%0d].underrun", tag, k), int'(ounderrun), int'(v.exp_ur));
      chk($sformatf("%s[%0d].lane", tag, k), int'(olane_idx), v.exp_lane);
      chk($sformatf("%s[%0d].data", tag, k), int'(odata), v.exp_data);
      tick();
      chk($sformatf("%s[%0d].pulse", tag, k),
          int'({odata_valid, ounderrun}), 0);
      tick();
      tick();
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, ".odata"}, int'(odata), 0);
    chk({tag, ".valid"}, int'(odata_valid), 0);
    chk({tag, ".lane"}, int'(olane_idx), 0);
    chk({tag, ".underrun"}, int'(ounderrun), 0);
    chk({tag, ".oready"}, int'(fif.oready), 1);
  endtask

  initial begin
    logic [NL*DW-1:0] f6;

    // underrun with no frame, then an ignored trig while disabled
    add(1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0);
    for (int i = 0; i < NL; i++) add(1, 1, 0, i, 100 + i);
    for (int i = 0; i < NL; i++) add(1, 1, 0, i, 200 + i);
    for (int i = 0; i < NL; i++) add(1, 1, 0, i, 300 + i);
    for (int i = 0; i < 8; i++) add(1, 1, 0, i, 100 + i);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 7, 107);
    for (int i = 8; i < NL; i++) add(1, 1, 0, i, 100 + i);
    add(1, 1, 0, 0, -32768);
    add(1, 1, 0, 1, -1);
    add(1, 1, 0, 2, 32767);
    add(1, 0, 1, 2, 0);

    fif.idata_lanes = '0;
    fif.ivalid      = 1'b0;
    f6 = '0;
    f6[0*DW +: DW] = 16'h8000;
    f6[1*DW +: DW] = 16'hFFFF;
    f6[2*DW +: DW] = 16'h7FFF;

    tick();
    tick();
    chk_reset_outs("reset");
    rtx_rst = 1'b1;
    tick();

    run_vecs(2, "underrun");

    load_frame(mk_frame(100));
    chk("accept.oready", int'(fif.oready), 0);
    tick();
    chk("xfer.oready", int'(fif.oready), 1);
    run_vecs(NL, "frame100");

    load_frame(mk_frame(200));
    load_frame(mk_frame(300));
    tick();
    chk("b_held.oready", int'(fif.oready), 0);
    run_vecs(2 * NL, "ab");
    chk("ab_done.oready", int'(fif.oready), 1);

    load_frame(mk_frame(100));
    tick();
    run_vecs(NL + 5, "enable");

    load_frame(f6);
    tick();
    run_vecs(3, "extreme");

    // queue a second frame so reset must drop both buffers
    load_frame(mk_frame(500));
    chk("pre_rst.oready", int'(fif.oready), 0);
    #3;
    rtx_rst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    tick();
    rtx_rst = 1'b1;
    tick();
    tick();
    vecs[0].exp_lane = 0;
    run_vecs(1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
